// File: rtl/sha256_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha256_pkg : shared state encoding and padding constants for the padder
// Rev 1.0
// ---------------------------------------------------------------------------
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    MARK   = 3'd2,
    ZERO   = 3'd3,
    LEN_HI = 3'd4,
    LEN_LO = 3'd5
  } state_t;

  localparam logic [7:0] PAD_BYTE      = 8'h80;
  localparam int         WORDS_PER_BLK = 16;
  localparam logic [3:0] LEN_IDX_HI    = 4'd14;
  localparam logic [3:0] LEN_IDX_LO    = 4'(WORDS_PER_BLK - 1);

  // i is the index of the word that carried the 0x80 marker
  function automatic state_t fill_next(input logic [3:0] i);
    return (i == LEN_IDX_HI - 4'd1) ? LEN_HI : ZERO;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_pad_word.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha256_pad_word : keeps bytes 0..k-1, inserts 0x80 at byte k, zeroes the rest
// Rev 1.0
// ---------------------------------------------------------------------------
module sha256_pad_word (
  input  logic [31:0] in_data,
  input  logic [2:0]  k,
  output logic [31:0] pad_data
);
  import sha256_pkg::*;

  // k == 4 leaves the word untouched; the marker then goes in a separate word
  always_comb begin
    pad_data = '0;
    for (int j = 0; j < 4; j++) begin
      if (3'(j) < k)
        pad_data[31-8*j -: 8] = in_data[31-8*j -: 8];
      else if (3'(j) == k)
        pad_data[31-8*j -: 8] = PAD_BYTE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sha256_msg_padder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha256_msg_padder : streams a message and emits padded 512-bit blocks
// Rev 1.0
// ---------------------------------------------------------------------------
module sha256_msg_padder #(
  parameter int LEN_W         = 64,
  parameter int WORDS_PER_BLK = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [2:0]       in_bytes,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_word_idx,
  output logic             out_block_end,
  output logic             out_msg_end,
  output logic             busy,
  output logic [LEN_W-1:0] len_bits
);
  import sha256_pkg::*;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [2:0]  w_k;
  logic [31:0] w_pad;
  logic [31:0] w_word;
  logic        w_emit;
  logic        w_load;
  logic        w_in_hs;
  logic [3:0]  w_cnt_nxt;

  assign w_k       = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign w_load    = !out_valid || out_ready;
  assign in_ready  = (r_state == DATA) && w_load;
  assign w_in_hs   = in_valid && in_ready;
  assign w_cnt_nxt = (r_cnt == 4'(WORDS_PER_BLK - 1)) ? 4'd0 : r_cnt + 4'd1;

  sha256_pad_word u_pad (
    .in_data  (in_data),
    .k        (w_k),
    .pad_data (w_pad)
  );

  // r_cnt is the index the next emitted word will carry
  always_comb begin
    w_emit = 1'b0;
    w_word = '0;
    case (r_state)
      DATA: begin
        w_emit = w_in_hs;
        w_word = in_last ? w_pad : in_data;
      end
      MARK: begin
        w_emit = w_load;
        w_word = {PAD_BYTE, 24'h0};
      end
      ZERO:   w_emit = w_load;
      LEN_HI: begin
        w_emit = w_load;
        w_word = len_bits[LEN_W-1:32];
      end
      LEN_LO: begin
        w_emit = w_load && !(out_valid && out_msg_end);
        w_word = len_bits[31:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      busy          <= 1'b0;
      len_bits      <= '0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_word_idx  <= '0;
      out_block_end <= 1'b0;
      out_msg_end   <= 1'b0;
    end else begin
      if (w_emit) begin
        out_valid     <= 1'b1;
        out_data      <= w_word;
        out_word_idx  <= r_cnt;
        out_block_end <= (r_cnt == LEN_IDX_LO);
        out_msg_end   <= (r_state == LEN_LO);
        r_cnt         <= w_cnt_nxt;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (r_state)
        IDLE: if (start) begin
          r_state  <= DATA;
          busy     <= 1'b1;
          len_bits <= '0;
          r_cnt    <= '0;
        end
        DATA: if (w_in_hs) begin
          if (in_last && w_k != 3'd4) begin
            len_bits <= len_bits + LEN_W'({w_k, 3'b000});
            r_state  <= fill_next(r_cnt);
          end else begin
            len_bits <= len_bits + LEN_W'(32);
            if (in_last)
              r_state <= MARK;
          end
        end
        MARK:   if (w_load) r_state <= fill_next(r_cnt);
        ZERO:   if (w_load && r_cnt == LEN_IDX_HI - 4'd1) r_state <= LEN_HI;
        LEN_HI: if (w_load) r_state <= LEN_LO;
        LEN_LO: if (out_valid && out_msg_end && out_ready) begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_padder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sha256_msg_padder : directed vectors against hand-computed padded blocks
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sha256_msg_padder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [2:0]  in_bytes;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_word_idx;
  logic        out_block_end;
  logic        out_msg_end;
  logic        busy;
  logic [63:0] len_bits;

  int checks = 0;
  int errors = 0;
  bit bp     = 1'b0;
  bit abort  = 1'b0;
  int bp_ph  = 0;

  logic [31:0] rx_data[$];
  logic [3:0]  rx_idx[$];
  bit          rx_be[$];
  bit          rx_me[$];
  logic [31:0] exp_w[32];
  logic [31:0] msg[16];
  bit          stall_prev = 1'b0;
  logic [31:0] stall_data;
  logic [3:0]  stall_idx;

  sha256_msg_padder #(.LEN_W(64), .WORDS_PER_BLK(16)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .start         (start),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_last       (in_last),
    .in_bytes      (in_bytes),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_word_idx  (out_word_idx),
    .out_block_end (out_block_end),
    .out_msg_end   (out_msg_end),
    .busy          (busy),
    .len_bits      (len_bits)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // out_ready follows 1-0-0-1 when backpressure is enabled
  always @(posedge CLK) begin
    #1;
    if (bp) begin
      out_ready = (bp_ph == 0 || bp_ph == 3);
      bp_ph     = (bp_ph + 1) % 4;
    end else begin
      out_ready = 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (out_valid && out_ready) begin
      rx_data.push_back(out_data);
      rx_idx.push_back(out_word_idx);
      rx_be.push_back(out_block_end);
      rx_me.push_back(out_msg_end);
    end
    if (stall_prev && out_valid && !RST) begin
      check_val("hold_data", {32'h0, out_data}, {32'h0, stall_data});
      check_val("hold_idx", {60'h0, out_word_idx}, {60'h0, stall_idx});
    end
    if (out_valid && !out_ready)
      check_val("in_ready_stall", {63'h0, in_ready}, 64'h0);
    stall_prev = out_valid && !out_ready;
    stall_data = out_data;
    stall_idx  = out_word_idx;
  end

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int  t    = 0;
    bit  done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    while (!done && !abort && t < 200) begin
      @(negedge CLK);
      done = in_ready;
      tick();
      t++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done && !abort)
      check_val("in_timeout", 64'h0, 64'h1);
  endtask

  task automatic send_msg(input int nw, input logic [2:0] lb);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < nw; i++) begin
      if (abort) break;
      send_word(msg[i], (i == nw - 1), (i == nw - 1) ? lb : 3'd0);
    end
  endtask

  task automatic clear_rx;
    rx_data.delete();
    rx_idx.delete();
    rx_be.delete();
    rx_me.delete();
  endtask

  task automatic run_block(input string tag, input int nw, input logic [2:0] lb,
                           input int nexp, input logic [63:0] exp_len);
    int t = 0;
    clear_rx();
    send_msg(nw, lb);
    while (rx_data.size() < nexp && t < 400) begin
      tick();
      t++;
    end
    repeat (4) tick();
    check_val({tag, "_count"}, 64'(rx_data.size()), 64'(nexp));
    for (int i = 0; i < nexp && i < rx_data.size(); i++) begin
      check_val($sformatf("%s_d%0d", tag, i), {32'h0, rx_data[i]}, {32'h0, exp_w[i]});
      check_val($sformatf("%s_i%0d", tag, i), {60'h0, rx_idx[i]}, 64'(i % 16));
      check_val($sformatf("%s_be%0d", tag, i), {63'h0, rx_be[i]}, {63'h0, (i % 16) == 15});
      check_val($sformatf("%s_me%0d", tag, i), {63'h0, rx_me[i]}, {63'h0, i == nexp - 1});
    end
    check_val({tag, "_busy"}, {63'h0, busy}, 64'h0);
    check_val({tag, "_len"}, len_bits, exp_len);
  endtask

  task automatic set_abc;
    msg[0] = 32'h61626300;
    foreach (exp_w[i]) exp_w[i] = 32'h0;
    exp_w[0]  = 32'h61626380;
    exp_w[15] = 32'h00000018;
  endtask

  task automatic set_msg14;
    for (int i = 0; i < 14; i++) msg[i] = 32'h41424344 + 32'(i);
    foreach (exp_w[i]) exp_w[i] = 32'h0;
    for (int i = 0; i < 14; i++) exp_w[i] = msg[i];
  endtask

  initial begin
    int t;
    RST      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 32'h0;
    in_bytes = 3'd0;
    repeat (2) tick();
    check_val("rst_valid", {63'h0, out_valid}, 64'h0);
    check_val("rst_busy", {63'h0, busy}, 64'h0);
    check_val("rst_len", len_bits, 64'h0);
    check_val("rst_ready", {63'h0, in_ready}, 64'h0);
    check_val("rst_data", {32'h0, out_data}, 64'h0);
    check_val("rst_flags", {61'h0, out_block_end, out_msg_end, |out_word_idx}, 64'h0);
    RST = 1'b0;
    tick();

    set_abc();
    run_block("abc", 1, 3'd3, 16, 64'd24);

    msg[0] = 32'hDEADBEEF;
    foreach (exp_w[i]) exp_w[i] = 32'h0;
    exp_w[0] = 32'h80000000;
    run_block("empty", 1, 3'd0, 16, 64'd0);

    set_msg14();
    exp_w[14] = 32'h80000000;
    exp_w[31] = 32'h000001C0;
    run_block("b56", 14, 3'd4, 32, 64'd448);
    run_block("b56x", 14, 3'd7, 32, 64'd448);

    set_msg14();
    exp_w[13] = {msg[13][31:8], 8'h80};
    exp_w[15] = 32'h000001B8;
    run_block("b55", 14, 3'd3, 16, 64'd440);

    bp    = 1'b1;
    bp_ph = 0;
    set_abc();
    run_block("bp", 1, 3'd3, 16, 64'd24);
    bp = 1'b0;
    tick();

    set_msg14();
    clear_rx();
    fork
      send_msg(14, 3'd3);
    join_none
    t = 0;
    while (rx_data.size() < 5 && t < 200) begin
      tick();
      t++;
    end
    check_val("mid_words", {63'h0, rx_data.size() >= 5}, 64'h1);
    @(negedge CLK);
    #2;
    RST   = 1'b1;
    abort = 1'b1;
    #1;
    check_val("mid_valid", {63'h0, out_valid}, 64'h0);
    check_val("mid_busy", {63'h0, busy}, 64'h0);
    check_val("mid_len", len_bits, 64'h0);
    check_val("mid_data", {32'h0, out_data}, 64'h0);
    check_val("mid_idx", {60'h0, out_word_idx}, 64'h0);
    check_val("mid_ready", {63'h0, in_ready}, 64'h0);
    repeat (3) tick();
    RST   = 1'b0;
    abort = 1'b0;
    tick();
    check_val("mid_idle", {62'h0, in_ready, out_valid}, 64'h0);

    set_abc();
    run_block("abc2", 1, 3'd3, 16, 64'd24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Upstream stage of the SHA-256 core. Accepts the raw message as a stream of 32-bit big-endian words and emits FIPS 180-4 padded 512-bit blocks as 16 sequential 32-bit words.
- Padding consists of the 0x80 marker, zero fill, and the 64-bit message bit length.
- Downstream, the 64-bit length/data holding registers and the message schedule consume the output word stream.

Parameters:
- LEN_W, 64, width of the bit-length counter. Fixed by the standard; other values are unsupported.
- WORDS_PER_BLK, 16, number of 32-bit words per 512-bit block.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse that begins a new message. Accepted only in IDLE.
- in_data  in  32  message word, big-endian (byte 0 = bits 31:24)
- in_valid  in  1  in_data valid
- in_ready  out  1  padder can accept a word
- in_last  in  1  final word of the message
- in_bytes  in  3  valid bytes in the final word, 0..4. Ignored unless in_last. Value 0 means an empty final word.
- out_data  out  32  padded word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_word_idx  out  4  word index within the current block, 0..15
- out_block_end  out  1  high with word 15 of every block
- out_msg_end  out  1  high with word 15 of the final block
- busy  out  1  high from an accepted start until the final word handshakes
- len_bits  out  LEN_W  running message length in bits

Behaviour:
- Reset values: all outputs 0, state IDLE, word counter 0, len_bits 0.
- Reset asserted mid-message aborts immediately. No partial block completes.
- Handshakes:
  - A transfer occurs when valid and ready are both high on a rising CLK.
  - Output is a single registered stage, so latency is 1 cycle from input handshake to out_valid.
  - in_ready = (state == DATA) && (!out_valid || out_ready).
  - While out_valid && !out_ready, out_data and all out_* sideband signals hold stable.
- States and transitions:
  - IDLE: on start, clear len_bits and word counter, go to DATA. busy = 1.
  - DATA: pass input words through.
    - Non-last word: emit in_data, len_bits += 32.
    - Last word with k = in_bytes in 0..3: emit bytes 0..k-1 of in_data, byte k = 0x80, lower bytes 0. len_bits += 8k. Go to ZERO or LEN_HI per the fill rule below.
    - Last word with k = 4: emit in_data, len_bits += 32, go to MARK.
    - in_bytes values 5..7 are treated as 4.
  - MARK: emit 0x80000000, then apply the fill rule.
  - Fill rule, where i = index of the word that carried 0x80:
    - i <= 12: go to ZERO.
    - i == 13: go to LEN_HI.
    - i is 14 or 15: go to ZERO. Zero-fill to index 15, wrap, then continue zero-fill at index 0 of the next block.
  - ZERO: emit 0x00000000 until the word counter reaches 14, then go to LEN_HI.
  - LEN_HI: emit len_bits[63:32], go to LEN_LO.
  - LEN_LO: emit len_bits[31:0] at index 15 with out_msg_end = 1. On handshake, go to IDLE and drop busy.
- Word counter:
  - Increments on every output handshake and wraps 15 -> 0.
  - out_block_end = (idx == 15).
- len_bits arithmetic:
  - Modulo 2^64. No overflow flag.
  - Frozen from the last input handshake until the next start.
- Boundary and ignored conditions:
  - start is ignored while busy.
  - in_valid is ignored outside DATA.
  - A start in the same cycle as the final out handshake is ignored, because state is still LEN_LO.

Decomposition:
- sha256_pkg:
  - State enum: IDLE, DATA, MARK, ZERO, LEN_HI, LEN_LO.
  - Constants: PAD_BYTE = 8'h80, WORDS_PER_BLK = 16, LEN_IDX_HI = 14, LEN_IDX_LO = 15.
- Sub-module sha256_pad_word (combinational):
  - Inputs: in_data, k.
  - Output: masked word with 0x80 inserted at byte k.
  - Reused for the k = 0 empty-word case.

Test Plan:
- "abc": one word 0x61626300, last, in_bytes = 3.
  - Expected block: idx0 0x61626380, idx1..14 0, idx15 0x00000018.
  - out_block_end and out_msg_end high at idx15.
- Empty message: start, then a single word with last and in_bytes = 0.
  - Expected block: idx0 0x80000000, idx1..15 0.
  - Exactly one block.
- 56-byte message (14 full words, last with in_bytes = 4).
  - Expected: idx14 0x80000000, idx15 0, out_block_end high, out_msg_end low.
  - Second block: idx0..13 0, idx14 0, idx15 0x000001C0.
- 55-byte message (last word at idx13 with in_bytes = 3).
  - Expected: idx13 low byte 0x80, idx14 0, idx15 0x000001B8.
  - Single block.
- Backpressure: "abc" with out_ready toggled 1-0-0-1.
  - out_data must hold while stalled, in_ready must stay low when the output register is full, and no words are dropped or duplicated.
- Reset mid-message: assert RST after 5 output words.
  - Outputs 0 and state IDLE immediately.
  - A following start with "abc" produces the exact first-scenario block.
